// File: rtl/stream_fifo_pkg.sv
// Shared constants and helpers for the stream FIFO slice.
package stream_fifo_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_DEPTH  = 8;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array: one synchronous write port, one asynchronous read port.
module fifo_mem
  import stream_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  localparam int unsigned AW    = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port; contents are intentionally never reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through stream FIFO with count, threshold flags and sticky overflow.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned AF_LVL = 6,
  parameter int unsigned AE_LVL = 2,
  localparam int unsigned CNT_W = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  input  logic              clr_flags
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             full_c, empty_c, wr_en_c, rd_en_c;

  // Occupancy decode from the wrap-bit pointers.
  always_comb begin
    full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty_c = (wr_ptr_q == rd_ptr_q);
    wr_en_c = in_valid && !full_c;
    rd_en_c = out_ready && !empty_c;
  end

  // Next-state for pointers, count and sticky overflow.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_en_c) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (rd_en_c) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    case ({wr_en_c, rd_en_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (clr_flags) overflow_d = 1'b0;
    if (in_valid && full_c) overflow_d = 1'b1;
  end

  // State registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en_c),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (out_data)
  );

  assign in_ready     = !full_c;
  assign out_valid    = !empty_c;
  assign count        = count_q;
  assign almost_full  = (count_q >= CNT_W'(AF_LVL));
  assign almost_empty = (count_q <= CNT_W'(AE_LVL));
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_stream_fifo.sv
// Directed scoreboard bench for stream_fifo (DATA_W=16, DEPTH=8, AF=6, AE=2).
module tb_stream_fifo;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic [3:0]  count;
  logic        almost_full;
  logic        almost_empty;
  logic        overflow;
  logic        clr_flags;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];
  bit ovf_m = 1'b0;

  stream_fifo #(
    .DATA_W (16),
    .DEPTH  (8),
    .AF_LVL (6),
    .AE_LVL (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .clr_flags    (clr_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare DUT state with the model, then advance one clock and update the model.
  task automatic cycle();
    bit full_m;
    bit wr;
    bit rd;
    int n;
    n      = sb.size();
    full_m = (n == DEPTH);
    chk("out_valid",    32'(out_valid),    32'(n != 0));
    chk("in_ready",     32'(in_ready),     32'(!full_m));
    chk("count",        32'(count),        32'(n));
    chk("almost_full",  32'(almost_full),  32'(n >= 6));
    chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
    chk("overflow",     32'(overflow),     32'(ovf_m));
    if (n != 0) chk("out_data", 32'(out_data), 32'(sb[0]));
    wr = in_valid && !full_m;
    rd = out_ready && (n != 0);
    @(posedge clk);
    #1;
    if (rst) begin
      sb.delete();
      ovf_m = 1'b0;
    end else begin
      if (rd) void'(sb.pop_front());
      if (wr) sb.push_back(in_data);
      ovf_m = (ovf_m && !clr_flags) || (in_valid && full_m);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_flags = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    cycle();

    // Fill to full with out_ready low.
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 16'(i);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    chk("full_in_ready", 32'(in_ready), 32'(0));

    // Drain all eight in order.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) cycle();
    chk("drained_valid", 32'(out_valid), 32'(0));
    cycle();
    out_ready = 1'b0;

    // Single word into empty FIFO.
    in_valid = 1'b1; in_data = 16'hA5A5;
    cycle();
    in_valid = 1'b0;
    chk("a5_valid", 32'(out_valid), 32'(1));
    chk("a5_data",  32'(out_data),  32'h0000_A5A5);
    cycle();
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;

    // Hold count at 4 while streaming 20 words through.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 16'(16'h0100 + i);
      cycle();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 16'(16'h0200 + i);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("stream_count", 32'(count), 32'(4));

    // Fill to full, then attempt a write that must be dropped.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 16'(16'h0300 + i);
      cycle();
    end
    in_data = 16'hDEAD;
    cycle();
    in_valid = 1'b0;
    chk("ovf_set", 32'(overflow), 32'(1));
    cycle();
    cycle();

    // Clear coinciding with a new overflow keeps the flag set.
    in_valid = 1'b1; clr_flags = 1'b1;
    cycle();
    in_valid = 1'b0; clr_flags = 1'b0;
    chk("ovf_clr_and_set", 32'(overflow), 32'(1));
    cycle();
    clr_flags = 1'b1;
    cycle();
    clr_flags = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'(0));
    cycle();

    // Drain to five then reset with a concurrent write and pop.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    out_ready = 1'b0;
    chk("pre_rst_count", 32'(count), 32'(5));
    rst = 1'b1; in_valid = 1'b1; in_data = 16'hBEEF; out_ready = 1'b1; clr_flags = 1'b1;
    cycle();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
    chk("rst_count",    32'(count),     32'(0));
    chk("rst_valid",    32'(out_valid), 32'(0));
    chk("rst_ready",    32'(in_ready),  32'(1));
    chk("rst_overflow", 32'(overflow),  32'(0));
    cycle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
